// File: rtl/ifid_hazard_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared MIPS32 decode constants for the IF/ID hazard stage.
//               Provides opcode values, the NOP encoding and the bit positions
//               of the op/rs/rt instruction fields.
// Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // sll $0,$0,0 -- the canonical all-zero bubble
  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage
`default_nettype wire

// File: rtl/ifid_hazard_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : ifid_hazard_stage_if
// Description : Bundles the fetch inputs, downstream-stage hazard sources and
//               the decode-side outputs of the IF/ID hazard stage.
//               master : fetch / pipeline side (drives inputs)
//               slave  : the IF/ID stage itself
// Revision    : 1.0  initial release
// ============================================================================
interface ifid_hazard_stage_if #(
  parameter int unsigned CNT_W = 16
);
  // fetch side
  logic [31:0]      iPC;
  logic [31:0]      iIR;
  logic             ivalid;
  logic             iflush;
  // downstream destination info
  logic             idex_mem_read;
  logic             idex_reg_write;
  logic [4:0]       idex_write_addr;
  logic             exmem_mem_read;
  logic [4:0]       exmem_write_addr;
  // decode side
  logic [31:0]      oPC;
  logic [31:0]      oIR;
  logic             ovalid;
  logic             pc_write;
  logic             hazard_detected;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output iPC, iIR, ivalid, iflush,
    output idex_mem_read, idex_reg_write, idex_write_addr,
    output exmem_mem_read, exmem_write_addr,
    input  oPC, oIR, ovalid, pc_write, hazard_detected,
    input  stall_count, flush_count
  );

  modport slave (
    input  iPC, iIR, ivalid, iflush,
    input  idex_mem_read, idex_reg_write, idex_write_addr,
    input  exmem_mem_read, exmem_write_addr,
    output oPC, oIR, ovalid, pc_write, hazard_detected,
    output stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/ifid_hazard_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational hazard detection for the instruction held in
//               IF/ID. Flags load-use (H1), branch-on-ALU (H2) and
//               branch-on-load (H3) dependencies.
//   valid            : IF/ID holds a real instruction
//   op, rs, rt       : decoded IF/ID fields
//   idex_*           : ID/EX load/write flags and destination
//   exmem_*          : EX/MEM load flag and destination
//   hazard_detected  : stall request for this cycle
// Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
  import mips_pkg::*;
(
  input  wire logic       valid,
  input  wire logic [5:0] op,
  input  wire logic [4:0] rs,
  input  wire logic [4:0] rt,
  input  wire logic       idex_mem_read,
  input  wire logic       idex_reg_write,
  input  wire logic [4:0] idex_write_addr,
  input  wire logic       exmem_mem_read,
  input  wire logic [4:0] exmem_write_addr,
  output logic            hazard_detected
);

  logic uses_rs;
  logic uses_rt;
  logic is_branch;
  logic idex_hit;
  logic exmem_hit;
  logic h1, h2, h3;

  always_comb begin
    uses_rs   = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
    uses_rt   = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    is_branch = (op == OP_BEQ) || (op == OP_BNE);

    // $0 is hardwired, so a write to it can never create a dependency
    idex_hit  = (idex_write_addr != 5'd0) &&
                ((uses_rs && (rs == idex_write_addr)) ||
                 (uses_rt && (rt == idex_write_addr)));
    exmem_hit = (exmem_write_addr != 5'd0) &&
                ((uses_rs && (rs == exmem_write_addr)) ||
                 (uses_rt && (rt == exmem_write_addr)));

    h1 = idex_mem_read && idex_hit;
    // branches compare in ID, so even ALU results one stage ahead are too late
    h2 = is_branch && idex_reg_write && idex_hit;
    h3 = is_branch && exmem_mem_read && exmem_hit;

    hazard_detected = valid && (h1 || h2 || h3);
  end

endmodule
`default_nettype wire

// File: rtl/ifid_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module      : ifid_hazard_stage
// Description : IF/ID pipeline register with integrated hazard detection,
//               stall/flush control and saturating performance counters.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : fetch inputs, ID/EX + EX/MEM hazard sources, decode outputs
//                  (oPC, oIR, ovalid, pc_write, hazard_detected, counters)
// Revision    : 1.0  initial release
// ============================================================================
module ifid_hazard_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  wire logic          clock,
  input  wire logic          reset,
  ifid_hazard_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hazard;
  logic             eflush;

  hazard_detect u_hazard_detect (
    .valid            (valid_q),
    .op               (ir_q[OP_MSB:OP_LSB]),
    .rs               (ir_q[RS_MSB:RS_LSB]),
    .rt               (ir_q[RT_MSB:RT_LSB]),
    .idex_mem_read    (bus.idex_mem_read),
    .idex_reg_write   (bus.idex_reg_write),
    .idex_write_addr  (bus.idex_write_addr),
    .exmem_mem_read   (bus.exmem_mem_read),
    .exmem_write_addr (bus.exmem_write_addr),
    .hazard_detected  (hazard)
  );

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // a branch resolved on stale operands must not redirect the pipeline
    eflush = bus.iflush && !hazard;

    if (hazard) begin
      // hold IF/ID so the dependent instruction is re-evaluated next cycle
    end else if (eflush || !bus.ivalid) begin
      pc_d    = bus.iPC;
      ir_d    = NOP;
      valid_d = 1'b0;
    end else begin
      pc_d    = bus.iPC;
      ir_d    = bus.iIR;
      valid_d = 1'b1;
    end

    if (hazard && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (eflush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      ir_q        <= NOP;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.oPC             = pc_q;
  assign bus.oIR             = ir_q;
  assign bus.ovalid          = valid_q;
  assign bus.hazard_detected = hazard;
  assign bus.pc_write        = !hazard;
  assign bus.stall_count     = stall_cnt_q;
  assign bus.flush_count     = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ifid_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifid_hazard_stage
// Description : Scoreboard testbench for ifid_hazard_stage. A driver applies
//               directed and random cycles and pushes the expected response
//               from a behavioural model; a monitor pops and compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ifid_hazard_stage;
  import mips_pkg::*;

  localparam int CW = 4;
  localparam logic [CW-1:0] SAT = '1;

  typedef struct packed {
    logic          hz;
    logic [31:0]   pc;
    logic [31:0]   ir;
    logic          v;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  ifid_hazard_stage_if #(.CNT_W(CW)) bus ();

  ifid_hazard_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // model state: what IF/ID should hold
  logic [31:0]   m_pc = 32'h0;
  logic [31:0]   m_ir = 32'h0;
  logic          m_v  = 1'b0;
  logic [CW-1:0] m_sc = '0;
  logic [CW-1:0] m_fc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] srcs[$], input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // source-register list of the held instruction, then dependency tests on it
  function automatic bit model_hazard(input bit v, input logic [31:0] ir,
                                      input bit imr, input bit irw, input logic [4:0] iwa,
                                      input bit emr, input logic [4:0] ewa);
    int op;
    bit br;
    logic [4:0] srcs[$];
    if (!v) return 1'b0;
    op = int'(ir[31:26]);
    if (!(op == 2 || op == 3 || op == 15)) srcs.push_back(ir[25:21]);
    if (op == 0 || op == 4 || op == 5 || op == 43) srcs.push_back(ir[20:16]);
    br = (op == 4 || op == 5);
    return (imr && reads(srcs, iwa)) ||
           (br && irw && reads(srcs, iwa)) ||
           (br && emr && reads(srcs, ewa));
  endfunction

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int lo);
    logic [5:0]  o = op[5:0];
    logic [4:0]  s = rs[4:0];
    logic [4:0]  t = rt[4:0];
    logic [15:0] l = lo[15:0];
    return {o, s, t, l};
  endfunction

  task automatic drive(input logic [31:0] ir, input bit iv, input bit fl,
                       input bit imr, input bit irw, input logic [4:0] iwa,
                       input bit emr, input logic [4:0] ewa);
    exp_t e;
    bit hz, ef;
    logic [31:0] pc;
    @(negedge clock);
    reset = 1'b0;
    pc = $urandom();
    bus.iPC = pc; bus.iIR = ir; bus.ivalid = iv; bus.iflush = fl;
    bus.idex_mem_read = imr; bus.idex_reg_write = irw; bus.idex_write_addr = iwa;
    bus.exmem_mem_read = emr; bus.exmem_write_addr = ewa;
    hz = model_hazard(m_v, m_ir, imr, irw, iwa, emr, ewa);
    ef = fl && !hz;
    if (hz) m_sc = (m_sc == SAT) ? SAT : m_sc + CW'(1);
    if (ef) m_fc = (m_fc == SAT) ? SAT : m_fc + CW'(1);
    if (!hz) begin
      m_pc = pc;
      if (ef || !iv) begin m_ir = 32'h0; m_v = 1'b0; end
      else begin m_ir = ir; m_v = 1'b1; end
    end
    e = '{hz, m_pc, m_ir, m_v, m_sc, m_fc};
    q.push_back(e);
  endtask

  // reset between edges; it stays high until the next drive releases it
  task automatic do_reset();
    @(negedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_oPC", bus.oPC, 32'h0);
    check("rst_oIR", bus.oIR, 32'h0);
    check("rst_ovalid", bus.ovalid, 0);
    check("rst_stall", bus.stall_count, 0);
    check("rst_flush", bus.flush_count, 0);
    check("rst_hazard", bus.hazard_detected, 0);
    check("rst_pc_write", bus.pc_write, 1);
    m_pc = 32'h0; m_ir = 32'h0; m_v = 1'b0; m_sc = '0; m_fc = '0;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("hazard", bus.hazard_detected, e.hz);
        check("pc_write", bus.pc_write, !e.hz);
        @(posedge clock);
        #1;
        check("oPC", bus.oPC, e.pc);
        check("oIR", bus.oIR, e.ir);
        check("ovalid", bus.ovalid, e.v);
        check("stall_count", bus.stall_count, e.sc);
        check("flush_count", bus.flush_count, e.fc);
      end
    end
  end

  // driver
  initial begin
    int ops[9] = '{0, 2, 3, 4, 5, 15, 43, 35, 8};
    logic [31:0] add321, beq20, junk;
    add321 = {6'd0, 5'd2, 5'd1, 5'd3, 5'd0, 6'h20};
    beq20  = mk(4, 2, 0, 16'h0010);
    junk   = mk(8, 9, 9, 16'h0001);

    bus.iPC = 0; bus.iIR = 0; bus.ivalid = 0; bus.iflush = 0;
    bus.idex_mem_read = 0; bus.idex_reg_write = 0; bus.idex_write_addr = 0;
    bus.exmem_mem_read = 0; bus.exmem_write_addr = 0;
    #1 reset = 1'b1;
    #1;
    check("init_oIR", bus.oIR, 32'h0);
    check("init_ovalid", bus.ovalid, 0);
    check("init_pc_write", bus.pc_write, 1);

    // load-use on a non-branch: one stall
    drive(add321, 1, 0, 0, 0, 0, 0, 0);
    drive(junk,   1, 0, 1, 0, 2, 0, 0);
    drive(junk,   1, 0, 0, 0, 0, 0, 0);

    // load then dependent branch: H1, H3, then taken flush
    drive(beq20, 1, 0, 0, 0, 0, 0, 0);
    drive(junk,  1, 0, 1, 1, 2, 0, 0);
    drive(junk,  1, 0, 0, 0, 0, 1, 2);
    drive(junk,  1, 1, 0, 0, 0, 0, 0);

    // flush arriving during a branch-on-ALU stall is ignored
    drive(beq20, 1, 0, 0, 0, 0, 0, 0);
    drive(junk,  1, 1, 0, 1, 2, 0, 0);
    drive(junk,  1, 0, 0, 0, 0, 0, 0);

    // $0 destination, lui rt field, j rs field: no stalls
    drive(mk(0, 0, 0, 16'h1820), 1, 0, 0, 0, 0, 0, 0);
    drive(junk,                  1, 0, 1, 1, 0, 1, 0);
    drive(mk(15, 0, 2, 16'h1234), 1, 0, 0, 0, 0, 0, 0);
    drive(junk,                  1, 0, 1, 1, 2, 0, 0);
    drive(mk(2, 2, 2, 16'h0040), 1, 0, 0, 0, 0, 0, 0);
    drive(junk,                  1, 1, 1, 1, 2, 1, 2);

    // held load-use saturates the stall counter, then reset mid-stall
    drive(add321, 1, 0, 0, 0, 0, 0, 0);
    repeat (20) drive(junk, 1, 0, 1, 0, 2, 0, 0);
    do_reset();

    // fetch bubble
    drive(add321, 1, 0, 0, 0, 0, 0, 0);
    drive(junk,   0, 0, 0, 0, 0, 0, 0);

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      drive(mk(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom()),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    @(posedge clock);
    #2;
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifid_hazard_stage.md
Name: ifid_hazard_stage

Overview:
IF/ID pipeline register plus hazard-detection unit for the 5-stage MIPS32 pipeline. Sits directly upstream of the ID/EX register and drives its hazard_detected input. It also consumes the ID/EX and EX/MEM destination information to detect load-use and branch-operand hazards. It stalls the PC and the IF/ID register, and flushes IF/ID on taken branches and jumps. Saturating stall and flush counters provide performance visibility.

Parameters:
RESET_PC, 32'h0000_0000, value loaded into oPC on reset.
CNT_W, 16, width of the saturating stall and flush performance counters.

Ports:
clock  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
iPC  in  32  PC+4 from fetch.
iIR  in  32  fetched instruction.
ivalid  in  1  fetch data valid (imem ready); 0 inserts a bubble.
iflush  in  1  taken branch or jump resolved in ID this cycle.
idex_mem_read  in  1  ID/EX omem_read.
idex_reg_write  in  1  ID/EX oreg_write.
idex_write_addr  in  5  ID/EX owrite_addr.
exmem_mem_read  in  1  EX/MEM mem_read.
exmem_write_addr  in  5  EX/MEM write address.
oPC  out  32  registered PC+4 to decode.
oIR  out  32  registered instruction to decode.
ovalid  out  1  IF/ID holds a real instruction.
pc_write  out  1  1 = PC may advance; 0 = hold PC.
hazard_detected  out  1  to ID/EX: insert bubble this cycle.
stall_count  out  CNT_W  saturating count of stall cycles.
flush_count  out  CNT_W  saturating count of applied flushes.

Behaviour:
- Reset (async): oPC=RESET_PC, oIR=0 (NOP), ovalid=0, stall_count=0, flush_count=0.
- Decoded from oIR: op=[31:26], rs=[25:21], rt=[20:16].
  - uses_rs: every opcode except j(2), jal(3), lui(15).
  - uses_rt: R-type(0), beq(4), bne(5), sw(43).
  - is_branch: op 4 or 5.
- Register 0 never causes a hazard. All hazard logic is gated by ovalid.
- Combinational hazard_detected = ovalid & (H1 | H2 | H3):
  - H1 load-use: idex_mem_read & idex_write_addr!=0 & ((uses_rs & rs==idex_write_addr) | (uses_rt & rt==idex_write_addr)).
  - H2 branch-on-ALU: is_branch & idex_reg_write & idex_write_addr!=0 & (rs or rt matches).
  - H3 branch-on-load: is_branch & exmem_mem_read & exmem_write_addr!=0 & (rs or rt matches).
- Resulting stall lengths: a load followed by a dependent branch stalls 2 cycles (H1, then H3). An ALU op followed by a dependent branch stalls 1 cycle. A load followed by a dependent non-branch stalls 1 cycle.
- pc_write = ~hazard_detected (combinational).
- Effective flush: eflush = iflush & ~hazard_detected. A branch resolved on stale operands is ignored.
- Clock-edge priority:
  1. hazard_detected: hold oPC/oIR/ovalid.
  2. eflush: oIR<=0, ovalid<=0, oPC<=iPC.
  3. ~ivalid: oIR<=0, ovalid<=0, oPC<=iPC.
  4. Otherwise: oPC<=iPC, oIR<=iIR, ovalid<=1.
- stall_count increments on each edge where hazard_detected=1. flush_count increments on each edge where eflush=1. Both saturate at all-ones and never wrap.
- Reset asserted mid-stall: outputs clear immediately; hazard_detected drops to 0 because ovalid=0.
- Latency: one cycle IF->ID. Stall and flush decisions are zero-latency (same cycle).

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LUI, OP_SW, OP_LW), NOP encoding, field bit positions.
- Sub-module hazard_detect: purely combinational H1/H2/H3, uses_rs/uses_rt decode, hazard_detected output.
- Top module holds the IF/ID register and the counters.

Test Plan:
- Reset mid-run: assert reset asynchronously between edges -> oPC=0, oIR=0, ovalid=0 and counters=0 before the next edge; pc_write=1.
- Load-use: IF/ID=add $3,$2,$1 with idex_mem_read=1, idex_write_addr=2 -> hazard_detected=1 and pc_write=0 for exactly 1 cycle; oIR held; stall_count 0->1.
- Load then beq $2,$0: cycle 1 via idex (addr 2), cycle 2 via exmem (addr 2) -> 2 stall cycles; on cycle 3 iflush=1 -> oIR=0, ovalid=0, flush_count=1.
- Flush during hazard: hazard_detected=1 and iflush=1 together -> flush ignored, oIR held, flush_count unchanged.
- Register zero and non-users: idex load to $0 -> no stall; lui with rt match on idex load -> no stall; j with rs-field match -> no stall.
- Counter saturation: CNT_W=4, hold a hazard for 20 cycles -> stall_count sticks at 4'hF; ivalid=0 -> bubble loaded (ovalid=0) with oPC=iPC.
